axi_accel_bridge: RTL
=====================

AXI_ACCEL_BRIDGE -- requirements
Module: axi_accel_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 128, AXI data width (multiple of 32, >= 64).
REQ-002 SHALL have parameter ID_W, default 12, AXI ID width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, instruction FIFO entries (power of two, >= 2).
REQ-004 SHALL have parameter NUM_PRED, default 2, 32-bit prediction channels; NUM_PRED*32 < DATA_W.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port s_axi_awid  in  ID_W  write burst ID.
REQ-008 SHALL have port s_axi_awlen  in  8  write beats minus one.
REQ-009 SHALL have port s_axi_awvalid  in  1  AW valid.
REQ-010 SHALL have port s_axi_awready  out  1  AW ready.
REQ-011 SHALL have port s_axi_wdata  in  DATA_W  write data; lane [31:0] carries instruction.
REQ-012 SHALL have port s_axi_wstrb  in  DATA_W/8  write strobes.
REQ-013 SHALL have port s_axi_wlast  in  1  last write beat.
REQ-014 SHALL have port s_axi_wvalid  in  1  W valid.
REQ-015 SHALL have port s_axi_wready  out  1  W ready.
REQ-016 SHALL have port s_axi_bid  out  ID_W  response ID.
REQ-017 SHALL have port s_axi_bresp  out  2  write response.
REQ-018 SHALL have port s_axi_bvalid  out  1  B valid.
REQ-019 SHALL have port s_axi_bready  in  1  B ready.
REQ-020 SHALL have port s_axi_arid  in  ID_W  read ID (single-beat reads only).
REQ-021 SHALL have port s_axi_arvalid  in  1  AR valid.
REQ-022 SHALL have port s_axi_arready  out  1  AR ready.
REQ-023 SHALL have port s_axi_rid  out  ID_W  read response ID.
REQ-024 SHALL have port s_axi_rdata  out  DATA_W  packed predictions plus status.
REQ-025 SHALL have port s_axi_rresp  out  2  read response, always 2'b00.
REQ-026 SHALL have port s_axi_rvalid  out  1  R valid.
REQ-027 SHALL have port s_axi_rready  in  1  R ready.
REQ-028 SHALL have port instr_data  out  32  FIFO head instruction.
REQ-029 SHALL have port instr_valid  out  1  FIFO non-empty.
REQ-030 SHALL have port instr_ready  in  1  pipeline pops head when instr_valid && instr_ready.
REQ-031 SHALL have port pred_data  in  NUM_PRED*32  accelerator predictions, channel k at [32k+31:32k].
REQ-032 SHALL have port pred_valid  in  1  pred_data valid this cycle.

Function
REQ-033 SHALL run write FSM WS_IDLE -> WS_DATA on AW handshake (awready=1 only in WS_IDLE; awid, awlen latched) -> WS_RESP after the last beat -> WS_IDLE on B handshake.
REQ-034 SHALL assert wready only in WS_DATA while FIFO not full; full with simultaneous pop still holds wready low.
REQ-035 SHALL push wdata[31:0] on every accepted beat with wstrb[3:0]==4'hF; beats with any of wstrb[3:0] low are dropped and set sticky error.
REQ-036 SHALL end a burst at beat count == awlen; wlast disagreeing with beat count sets sticky error; error gives bresp=2'b10, else 2'b00; bid=latched awid; bvalid held until bready.
REQ-037 SHALL present pushed word on instr_data/instr_valid one cycle after the W handshake (FIFO empty case); FIFO order strict FIFO, pointers wrap modulo FIFO_DEPTH.
REQ-038 SHALL latch pred_data on pred_valid and set a fresh flag; R handshake clears fresh unless pred_valid same cycle (set wins).
REQ-039 SHALL accept AR (arready=1) only when no R pending; rvalid asserted the next cycle, rdata/rid registered at AR handshake and stable until rready.
REQ-040 SHALL pack rdata = latched predictions in [NUM_PRED*32-1:0], fresh flag in bit DATA_W-1, all other bits zero.

Reset
REQ-041 SHALL on reset (any time, including mid-burst) clear FSM to WS_IDLE, empty FIFO, clear error/fresh/prediction latch; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, instr_valid=0, instr_data/rdata/bid/rid/bresp/rresp=0.

Structure
REQ-042 SHALL place write-FSM state enumeration and AXI response constants (OKAY=2'b00, SLVERR=2'b10) in shared package axi_accel_pkg.
REQ-043 SHALL implement the instruction FIFO as sub-module instr_fifo (parameters FIFO_DEPTH, width 32).

Verification
REQ-044 SHALL test awlen=3 burst, wstrb all ones, instr_ready=1: four words pop in order, bresp=2'b00, bid echoes awid.
REQ-045 SHALL test FIFO_DEPTH=8, instr_ready=0, awlen=9: wready drops after beat 8, resumes after one pop, all 10 words delivered.
REQ-046 SHALL test beat 2 with wstrb[3:0]=4'h7: word dropped, bresp=2'b10; early wlast on beat 1 of awlen=3 gives bresp=2'b10.
REQ-047 SHALL test pred_data=64'h0000_0002_0000_0001 with pred_valid, then AR: rdata[63:0] matches, rdata[127]=1; second AR returns rdata[127]=0.
REQ-048 SHALL test reset asserted mid-burst after beat 1: instr_valid=0, awready=1 next cycle, new burst completes normally.

Source files
------------

// File: rtl/axi_accel_pkg.sv
// Shared types and constants for the AXI accelerator bridge: the write-channel
// state encoding and the AXI response codes.
package axi_accel_pkg;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_DATA = 2'd1,
        WS_RESP = 2'd2
    } wstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_accel_bridge_if.sv
// AXI4 slave-side bundle for the accelerator bridge (write burst, single-beat read).
interface axi_accel_bridge_if #(
    parameter int DATA_W = 128,
    parameter int ID_W   = 12
);
    logic [ID_W-1:0]     s_axi_awid;
    logic [7:0]          s_axi_awlen;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ID_W-1:0]     s_axi_arid;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [ID_W-1:0]     s_axi_rid;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awlen, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_bready, s_axi_arid, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awid, s_axi_awlen, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_bready, s_axi_arid, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/instr_fifo.sv
// Instruction FIFO: power-of-two circular buffer; head is visible the cycle
// after a push into an empty FIFO and reads as zero while empty.
module instr_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/axi_accel_bridge.sv
// AXI slave front end for the accelerator: write bursts feed the instruction
// FIFO, single-beat reads return the latest latched predictions plus a fresh flag.
module axi_accel_bridge
    import axi_accel_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ID_W       = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_PRED   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_accel_bridge_if.slave      axi,
    output logic [31:0]            instr_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic [NUM_PRED*32-1:0] pred_data,
    input  logic                   pred_valid
);
    wstate_t         state, state_nxt;
    logic            awready, wready, bvalid;
    logic            fifo_full, push, w_hs, beat_last, strb_ok;
    logic [ID_W-1:0] awid_q;
    logic [7:0]      awlen_q, beat_cnt;
    logic            err;

    logic [NUM_PRED*32-1:0] pred_q;
    logic                   fresh, rvalid;
    logic [ID_W-1:0]        rid;
    logic [DATA_W-1:0]      rdata, rdata_pack;
    logic                   ar_hs, r_hs;
    logic                   unused_bits;

    assign unused_bits = ^{axi.s_axi_wdata[DATA_W-1:32], axi.s_axi_wstrb[DATA_W/8-1:4]};

    assign beat_last = (beat_cnt == awlen_q);
    assign strb_ok   = (axi.s_axi_wstrb[3:0] == 4'hF);
    assign w_hs      = wready && axi.s_axi_wvalid;
    assign push      = w_hs && strb_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (state)
            WS_IDLE: begin
                awready = 1'b1;
                if (axi.s_axi_awvalid) state_nxt = WS_DATA;
            end
            WS_DATA: begin
                wready = !fifo_full;
                if (wready && axi.s_axi_wvalid && beat_last) state_nxt = WS_RESP;
            end
            WS_RESP: begin
                bvalid = 1'b1;
                if (axi.s_axi_bready) state_nxt = WS_IDLE;
            end
            default: state_nxt = WS_IDLE;
        endcase
    end

    // Error is sticky for the burst and cleared when the next burst is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awid_q   <= '0;
            awlen_q  <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (awready && axi.s_axi_awvalid) begin
            awid_q   <= axi.s_axi_awid;
            awlen_q  <= axi.s_axi_awlen;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (!strb_ok || (axi.s_axi_wlast != beat_last)) err <= 1'b1;
        end
    end

    assign axi.s_axi_awready = awready;
    assign axi.s_axi_wready  = wready;
    assign axi.s_axi_bvalid  = bvalid;
    assign axi.s_axi_bid     = awid_q;
    assign axi.s_axi_bresp   = err ? RESP_SLVERR : RESP_OKAY;

    instr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (axi.s_axi_wdata[31:0]),
        .pop       (instr_ready),
        .full      (fifo_full),
        .valid     (instr_valid),
        .head      (instr_data)
    );

    assign ar_hs = axi.s_axi_arvalid && !rvalid;
    assign r_hs  = rvalid && axi.s_axi_rready;

    always_comb begin
        rdata_pack                   = '0;
        rdata_pack[NUM_PRED*32-1:0]  = pred_q;
        rdata_pack[DATA_W-1]         = fresh;
    end

    // A new prediction in the same cycle as the R handshake keeps fresh set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_q <= '0;
            fresh  <= 1'b0;
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
        end else begin
            if (pred_valid) begin
                pred_q <= pred_data;
                fresh  <= 1'b1;
            end else if (r_hs) begin
                fresh  <= 1'b0;
            end
            if (ar_hs) begin
                rvalid <= 1'b1;
                rid    <= axi.s_axi_arid;
                rdata  <= rdata_pack;
            end else if (r_hs) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign axi.s_axi_arready = !rvalid;
    assign axi.s_axi_rvalid  = rvalid;
    assign axi.s_axi_rid     = rid;
    assign axi.s_axi_rdata   = rdata;
    assign axi.s_axi_rresp   = RESP_OKAY;

endmodule
